// File: rtl/jtag_seq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jtag_seq_arbiter
// Purpose  : Two-requester, sequence-granular arbiter in front of the JTAG
//            sequencer command FIFO, with TDO/flush return routing.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_seq_arbiter #(
   parameter int TIMEOUT = 100000,
   parameter int TO_W    = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_empty,
   input  logic [7:0] req0_tms,
   input  logic [7:0] req0_tdi,
   input  logic [2:0] req0_bits,
   input  logic [4:0] req0_command,
   input  logic [7:0] req0_read,
   output logic       req0_re,
   input  logic       req1_empty,
   input  logic [7:0] req1_tms,
   input  logic [7:0] req1_tdi,
   input  logic [2:0] req1_bits,
   input  logic [4:0] req1_command,
   input  logic [7:0] req1_read,
   output logic       req1_re,
   output logic       out_seq_empty,
   output logic [7:0] out_seq_tms,
   output logic [7:0] out_seq_tdi,
   output logic [2:0] out_seq_bits,
   output logic [4:0] out_seq_command,
   output logic [7:0] out_seq_read,
   input  logic       out_seq_re,
   input  logic       in_seq_we,
   input  logic [7:0] in_seq_tdo,
   input  logic       in_seq_flushed,
   output logic       in_seq_full,
   input  logic       rsp0_full,
   input  logic       rsp1_full,
   output logic       rsp0_we,
   output logic [7:0] rsp0_tdo,
   output logic       rsp0_flushed,
   output logic       rsp1_we,
   output logic [7:0] rsp1_tdo,
   output logic       rsp1_flushed,
   output logic [1:0] arb_timeout
);

   localparam logic [4:0]      c_CMD_STORE = 5'h05;
   localparam logic [4:0]      c_CMD_FLUSH = 5'h07;
   localparam logic [TO_W-1:0] c_TO_LAST   = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_owner;
   logic            r_last;
   logic [12:0]     r_store_rem;
   logic [1:0]      r_drain_cnt;
   logic [TO_W-1:0] r_to_cnt;

   logic       w_own_empty;
   logic [7:0] w_head_tms;
   logic [7:0] w_head_tdi;
   logic [2:0] w_head_bits;
   logic [4:0] w_head_cmd;
   logic [7:0] w_head_read;
   logic       w_mux_en;
   logic       w_pop;
   logic       w_in_payload;
   logic       w_idle_own;
   logic       w_to_fire;
   logic       w_flush_pop;
   logic       w_drain_done;
   logic       w_grant;

   assign w_own_empty = r_owner ? req1_empty   : req0_empty;
   assign w_head_tms  = r_owner ? req1_tms     : req0_tms;
   assign w_head_tdi  = r_owner ? req1_tdi     : req0_tdi;
   assign w_head_bits = r_owner ? req1_bits    : req0_bits;
   assign w_head_cmd  = r_owner ? req1_command : req0_command;
   assign w_head_read = r_owner ? req1_read    : req0_read;

   assign w_mux_en      = (r_state != ST_IDLE);
   assign out_seq_empty = ~((r_state == ST_OWN) & ~w_own_empty);
   assign out_seq_tms     = w_mux_en ? w_head_tms  : 8'h00;
   assign out_seq_tdi     = w_mux_en ? w_head_tdi  : 8'h00;
   assign out_seq_bits    = w_mux_en ? w_head_bits : 3'h0;
   assign out_seq_command = w_mux_en ? w_head_cmd  : 5'h00;
   assign out_seq_read    = w_mux_en ? w_head_read : 8'h00;

   assign req0_re = out_seq_re & (r_state == ST_OWN) & ~r_owner;
   assign req1_re = out_seq_re & (r_state == ST_OWN) &  r_owner;

   assign w_pop        = out_seq_re & ~out_seq_empty;
   assign w_in_payload = (r_store_rem != 13'd0);
   // Payload words are opaque: a FLUSH code inside STORE data must not end ownership.
   assign w_flush_pop  = (r_state == ST_OWN) & w_pop & ~w_in_payload & (w_head_cmd == c_CMD_FLUSH);
   assign w_idle_own   = (r_state == ST_OWN) & w_own_empty & ~w_in_payload;
   assign w_to_fire    = (TIMEOUT != 0) & w_idle_own & (r_to_cnt == c_TO_LAST);
   assign w_drain_done = (r_state == ST_DRAIN) & r_drain_cnt[1] & in_seq_flushed;
   assign w_grant      = (~req0_empty & ~req1_empty) ? ~r_last : req0_empty;

   assign rsp0_we      = in_seq_we & w_mux_en & ~r_owner;
   assign rsp1_we      = in_seq_we & w_mux_en &  r_owner;
   assign rsp0_tdo     = in_seq_tdo;
   assign rsp1_tdo     = in_seq_tdo;
   assign in_seq_full  = w_mux_en & (r_owner ? rsp1_full : rsp0_full);
   assign rsp0_flushed = w_drain_done & ~r_owner;
   assign rsp1_flushed = w_drain_done &  r_owner;
   assign arb_timeout  = {w_to_fire & r_owner, w_to_fire & ~r_owner};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (~req0_empty | ~req1_empty) begin
               w_state_nxt = ST_OWN;
            end
         end
         ST_OWN: begin
            if (w_flush_pop) begin
               w_state_nxt = ST_DRAIN;
            end else if (w_to_fire) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (w_drain_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_store_rem <= 13'd0;
         r_drain_cnt <= 2'd0;
         r_to_cnt    <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (~req0_empty | ~req1_empty) begin
                  r_owner     <= w_grant;
                  r_to_cnt    <= '0;
                  r_store_rem <= 13'd0;
               end
            end
            ST_OWN: begin
               if (w_pop) begin
                  r_to_cnt <= '0;
                  if (w_in_payload) begin
                     r_store_rem <= r_store_rem - 13'd1;
                  end else if (w_head_cmd == c_CMD_STORE) begin
                     r_store_rem <= {w_head_tdi, w_head_tms[7:3]} + {12'd0, |w_head_tms[2:0]};
                  end
                  if (w_flush_pop) begin
                     r_drain_cnt <= 2'd0;
                  end
               end else if (w_to_fire) begin
                  r_last   <= r_owner;
                  r_to_cnt <= '0;
               end else if (w_idle_own) begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               // The count saturates at 2 so the minimum drain time is guaranteed.
               if (w_drain_done) begin
                  r_last <= r_owner;
               end else if (!r_drain_cnt[1]) begin
                  r_drain_cnt <= r_drain_cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtag_seq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for jtag_seq_arbiter: directed scenarios followed by randomized
// traffic, all checked against a sequence-level behavioural model.
module tb_jtag_seq_arbiter;

   localparam int         TMO       = 16;
   localparam logic [4:0] CMD_WR    = 5'h01;
   localparam logic [4:0] CMD_STORE = 5'h05;
   localparam logic [4:0] CMD_FLUSH = 5'h07;

   logic clk, rst;
   logic req0_empty, req1_empty, req0_re, req1_re;
   logic [7:0] req0_tms, req0_tdi, req0_read, req1_tms, req1_tdi, req1_read;
   logic [2:0] req0_bits, req1_bits;
   logic [4:0] req0_command, req1_command;
   logic out_seq_empty, out_seq_re, in_seq_we, in_seq_flushed, in_seq_full;
   logic [7:0] out_seq_tms, out_seq_tdi, out_seq_read, in_seq_tdo, rsp0_tdo, rsp1_tdo;
   logic [2:0] out_seq_bits;
   logic [4:0] out_seq_command;
   logic rsp0_full, rsp1_full, rsp0_we, rsp1_we, rsp0_flushed, rsp1_flushed;
   logic [1:0] arb_timeout;

   jtag_seq_arbiter #(.TIMEOUT(TMO), .TO_W(5)) dut (
      .clk(clk), .rst(rst),
      .req0_empty(req0_empty), .req0_tms(req0_tms), .req0_tdi(req0_tdi), .req0_bits(req0_bits),
      .req0_command(req0_command), .req0_read(req0_read), .req0_re(req0_re),
      .req1_empty(req1_empty), .req1_tms(req1_tms), .req1_tdi(req1_tdi), .req1_bits(req1_bits),
      .req1_command(req1_command), .req1_read(req1_read), .req1_re(req1_re),
      .out_seq_empty(out_seq_empty), .out_seq_tms(out_seq_tms), .out_seq_tdi(out_seq_tdi),
      .out_seq_bits(out_seq_bits), .out_seq_command(out_seq_command), .out_seq_read(out_seq_read),
      .out_seq_re(out_seq_re), .in_seq_we(in_seq_we), .in_seq_tdo(in_seq_tdo),
      .in_seq_flushed(in_seq_flushed), .in_seq_full(in_seq_full),
      .rsp0_full(rsp0_full), .rsp1_full(rsp1_full),
      .rsp0_we(rsp0_we), .rsp0_tdo(rsp0_tdo), .rsp0_flushed(rsp0_flushed),
      .rsp1_we(rsp1_we), .rsp1_tdo(rsp1_tdo), .rsp1_flushed(rsp1_flushed),
      .arb_timeout(arb_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word layout: {tms[31:24], tdi[23:16], bits[15:13], cmd[12:8], read[7:0]}
   logic [31:0] q0[$], q1[$], pend0[$], pend1[$];
   logic d_re, d_we, d_fl, d_f0, d_f1;
   logic [7:0] d_tdo;

   // Model: phase 0 = nobody owns, 1 = sequence streaming, 2 = waiting for flush
   int m_phase, m_who, m_prev, m_payload, m_age, m_quiet;

   int n_checks, n_err, cyc, to_cyc, pop_cyc;
   int fl_cyc[2];
   int we_cnt[2];
   int src_log[$];
   logic obs_full;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] tms, input logic [7:0] tdi,
                                      input logic [4:0] cmd, input logic [7:0] rd);
      return {tms, tdi, 3'd0, cmd, rd};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_who = 0; m_prev = 1; m_payload = 0; m_age = 0; m_quiet = 0;
   endtask

   task automatic step();
      logic [31:0] h0, h1, hw, exp_data;
      logic e0, e1, ew, exp_empty, fl_ok, tmo, pop;
      logic [1:0] exp_re, exp_we, exp_fl, exp_to;
      e0 = (q0.size() == 0); h0 = e0 ? 32'd0 : q0[0];
      e1 = (q1.size() == 0); h1 = e1 ? 32'd0 : q1[0];
      req0_empty = e0; {req0_tms, req0_tdi, req0_bits, req0_command, req0_read} = h0;
      req1_empty = e1; {req1_tms, req1_tdi, req1_bits, req1_command, req1_read} = h1;
      out_seq_re = d_re; in_seq_we = d_we; in_seq_tdo = d_tdo; in_seq_flushed = d_fl;
      rsp0_full = d_f0; rsp1_full = d_f1;
      @(negedge clk);
      ew = (m_who == 1) ? e1 : e0;
      hw = (m_who == 1) ? h1 : h0;
      exp_empty = !(m_phase == 1 && !ew);
      exp_data  = (m_phase == 0) ? 32'd0 : hw;
      exp_re    = (d_re && m_phase == 1) ? 2'(1 << m_who) : 2'b00;
      exp_we    = (d_we && m_phase != 0) ? 2'(1 << m_who) : 2'b00;
      fl_ok     = (m_phase == 2 && m_age >= 2 && d_fl);
      exp_fl    = fl_ok ? 2'(1 << m_who) : 2'b00;
      tmo       = (m_phase == 1 && ew && m_payload == 0 && m_quiet + 1 == TMO);
      exp_to    = tmo ? 2'(1 << m_who) : 2'b00;
      chk("out_seq_empty", out_seq_empty, exp_empty);
      chk("out_seq_data", {out_seq_tms, out_seq_tdi, out_seq_bits, out_seq_command, out_seq_read}, exp_data);
      chk("req_re", {req1_re, req0_re}, exp_re);
      chk("rsp_we", {rsp1_we, rsp0_we}, exp_we);
      chk("rsp_tdo", {rsp1_tdo, rsp0_tdo}, {d_tdo, d_tdo});
      chk("in_seq_full", in_seq_full, (m_phase != 0) && ((m_who == 1) ? d_f1 : d_f0));
      chk("rsp_flushed", {rsp1_flushed, rsp0_flushed}, exp_fl);
      chk("arb_timeout", arb_timeout, exp_to);
      obs_full = in_seq_full;
      we_cnt[0] += int'(rsp0_we);
      we_cnt[1] += int'(rsp1_we);
      if (fl_ok) fl_cyc[m_who] = cyc;
      if (tmo) to_cyc = cyc;
      pop = d_re && !exp_empty;
      case (m_phase)
         0: if (!e0 || !e1) begin
               m_who = (!e0 && !e1) ? 1 - m_prev : (e0 ? 1 : 0);
               m_phase = 1; m_quiet = 0; m_payload = 0;
            end
         1: if (pop) begin
               pop_cyc = cyc; src_log.push_back(m_who); m_quiet = 0;
               if (m_payload > 0) m_payload--;
               else if (hw[12:8] == CMD_STORE)
                  m_payload = (int'(hw[23:16]) * 32 + int'(hw[31:27]) + ((hw[26:24] != 0) ? 1 : 0)) % 8192;
               else if (hw[12:8] == CMD_FLUSH) begin m_phase = 2; m_age = 0; end
            end else if (tmo) begin
               m_phase = 0; m_prev = m_who;
            end else if (ew && m_payload == 0) m_quiet++;
         default: if (fl_ok) begin m_phase = 0; m_prev = m_who; end
                  else if (m_age < 2) m_age++;
      endcase
      @(posedge clk); #1;
      if (exp_re[0] && q0.size() > 0) void'(q0.pop_front());
      if (exp_re[1] && q1.size() > 0) void'(q1.pop_front());
      cyc++;
   endtask

   task automatic push_pend(input int which, input logic [31:0] w);
      if (which == 0) pend0.push_back(w); else pend1.push_back(w);
   endtask

   task automatic gen_seq(input int which);
      int n;
      logic [4:0] c;
      logic [7:0] t;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            t = 8'($urandom_range(0, 31));
            push_pend(which, mk(t, 8'h00, CMD_STORE, 8'($urandom)));
            for (int k = 0; k < int'(t[7:3]) + ((t[2:0] != 0) ? 1 : 0); k++) begin
               c = ($urandom_range(0, 2) == 0) ? CMD_FLUSH : 5'($urandom);
               push_pend(which, mk(8'($urandom), 8'($urandom), c, 8'($urandom)));
            end
         end else begin
            c = 5'($urandom);
            if (c == CMD_STORE || c == CMD_FLUSH) c = CMD_WR;
            push_pend(which, mk(8'($urandom), 8'($urandom), c, 8'($urandom)));
         end
      end
      push_pend(which, mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, p, rate0, rate1;
      n_checks = 0; n_err = 0; cyc = 0; to_cyc = -1; pop_cyc = -1;
      fl_cyc[0] = -1; fl_cyc[1] = -1; we_cnt[0] = 0; we_cnt[1] = 0;
      model_reset();
      rst = 1'b0;
      d_re = 1'b1; d_we = 1'b1; d_tdo = 8'h00; d_fl = 1'b1; d_f0 = 1'b1; d_f1 = 1'b1;
      req0_empty = 1'b1; req1_empty = 1'b1;
      {req0_tms, req0_tdi, req0_bits, req0_command, req0_read} = '0;
      {req1_tms, req1_tdi, req1_bits, req1_command, req1_read} = '0;
      out_seq_re = 1'b1; in_seq_we = 1'b1; in_seq_tdo = 8'h00; in_seq_flushed = 1'b1;
      rsp0_full = 1'b1; rsp1_full = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("reset_empty", out_seq_empty, 1'b1);
      chk("reset_outs", {req1_re, req0_re, rsp1_we, rsp0_we, rsp1_flushed, rsp0_flushed,
                         in_seq_full, arb_timeout, out_seq_tms, out_seq_command}, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      d_we = 1'b0; d_f0 = 1'b0; d_f1 = 1'b0;

      // Both requesters present a WR+FLUSH sequence in the same cycle.
      q0.push_back(mk(8'h00, 8'hA5, CMD_WR, 8'h00)); q0.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      q1.push_back(mk(8'h00, 8'hA5, CMD_WR, 8'h00)); q1.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      repeat (12) step();
      chk("t1_pop_count", src_log.size(), 4);
      if (src_log.size() == 4) chk("t1_order", {src_log[0], src_log[1], src_log[2], src_log[3]}, {32'd0, 32'd0, 32'd1, 32'd1});
      chk("t1_flush0_seen", fl_cyc[0] >= 0, 1'b1);
      chk("t1_flush1_after", fl_cyc[1] > fl_cyc[0], 1'b1);

      // STORE payload containing FLUSH codes must not end the sequence.
      src_log.delete(); d_fl = 1'b0;
      q0.push_back(mk(8'h1A, 8'h00, CMD_STORE, 8'h00));
      for (int i = 0; i < 4; i++) q0.push_back(mk(8'($urandom), 8'($urandom), CMD_FLUSH, 8'h00));
      q0.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      q0.push_back(mk(8'h3C, 8'h11, CMD_WR, 8'h00));
      repeat (10) step();
      chk("t2_pops_to_drain", src_log.size(), 6);
      chk("t2_left_in_fifo", q0.size(), 1);

      // Lone WR then stall: forced release after TMO idle cycles, req1 next.
      d_fl = 1'b1;
      repeat (6) step();
      chk("t4_last_pop_src", (src_log.size() > 0) ? src_log[src_log.size() - 1] : -1, 0);
      p = pop_cyc; to_cyc = -1;
      q1.push_back(mk(8'h01, 8'h02, CMD_WR, 8'h00)); q1.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      for (int i = 0; i < 40 && to_cyc < 0; i++) step();
      chk("t4_timeout_delay", to_cyc - p, TMO);
      repeat (3) step();
      chk("t4_req1_granted", src_log[src_log.size() - 1], 1);
      repeat (6) step();

      // req1 read sequence: three TDO bytes, the last two cycles after the FLUSH pop.
      we_cnt[0] = 0; we_cnt[1] = 0; fl_cyc[1] = -1; t = -1;
      q1.push_back(mk(8'h00, 8'h00, CMD_WR, 8'hFF)); q1.push_back(mk(8'h00, 8'h00, CMD_WR, 8'hFF));
      q1.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      for (int i = 0; i < 20; i++) begin
         if (t < 0 && m_phase == 1 && m_who == 1 && m_payload == 0 && q1.size() > 0 && q1[0][12:8] == CMD_FLUSH)
            t = cyc;
         d_we = (t >= 0 && cyc <= t + 2);
         d_tdo = 8'($urandom);
         step();
      end
      d_we = 1'b0;
      chk("t3_rsp1_bytes", we_cnt[1], 3);
      chk("t3_rsp0_bytes", we_cnt[0], 0);
      chk("t3_flush_lat", fl_cyc[1] - t, 3);

      // Response-full follows the owner only.
      d_re = 1'b0;
      q0.push_back(mk(8'h00, 8'h00, CMD_WR, 8'h00)); q0.push_back(mk(8'h00, 8'h00, CMD_WR, 8'h00));
      q0.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      repeat (2) step();
      d_f0 = 1'b1; d_f1 = 1'b0; step();
      chk("t5_full_owner", obs_full, 1'b1);
      d_f0 = 1'b0; d_f1 = 1'b1; step();
      chk("t5_full_other", obs_full, 1'b0);
      d_f1 = 1'b0; d_re = 1'b1; d_fl = 1'b0;
      repeat (4) step();

      // Asynchronous reset while draining.
      q0.push_back(mk(8'h00, 8'h00, CMD_WR, 8'h00)); q0.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      q1.push_back(mk(8'h00, 8'h00, CMD_WR, 8'h00)); q1.push_back(mk(8'h00, 8'h00, CMD_FLUSH, 8'h00));
      repeat (2) step();
      d_fl = 1'b1; in_seq_flushed = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_empty", out_seq_empty, 1'b1);
      chk("t6_rst_re", {req1_re, req0_re}, 2'b00);
      chk("t6_rst_flushed", {rsp1_flushed, rsp0_flushed}, 2'b00);
      @(posedge clk); #2;
      rst = 1'b1;
      model_reset(); src_log.delete();
      repeat (3) step();
      chk("t6_first_grant", (src_log.size() > 0) ? src_log[0] : -1, 0);

      // Randomized traffic.
      rate0 = 30; rate1 = 30;
      for (int i = 0; i < 2500; i++) begin
         if (i % 100 == 0) begin
            case ($urandom_range(0, 2)) 0: rate0 = 3; 1: rate0 = 30; default: rate0 = 80; endcase
            case ($urandom_range(0, 2)) 0: rate1 = 3; 1: rate1 = 30; default: rate1 = 80; endcase
         end
         d_re = ($urandom_range(0, 3) != 0); d_we = ($urandom_range(0, 2) == 0);
         d_tdo = 8'($urandom); d_fl = 1'($urandom); d_f0 = 1'($urandom); d_f1 = 1'($urandom);
         if (pend0.size() == 0) gen_seq(0);
         if (pend1.size() == 0) gen_seq(1);
         if ($urandom_range(0, 99) < rate0) q0.push_back(pend0.pop_front());
         if ($urandom_range(0, 99) < rate1) q1.push_back(pend1.pop_front());
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtag_seq_arbiter.md
Name: jtag_seq_arbiter

Overview:
- Shares the single JTAG sequencer command FIFO (out_seq_*) and its TDO return path (in_seq_*) between two producers: requester 0 (host/USB command path) and requester 1 (PC-sampling engine).
- Each requester keeps ownership for a whole sequence, from its first word up to and including a FLUSH command, so sequences never interleave.
- Returned TDO bytes and flush completion are routed back to the owner.
- Sits between the two producer FIFOs and jtag_controller.

Parameters:
TIMEOUT, 100000, number of idle-owner cycles before forced release; 0 disables the timeout
TO_W, 17, timeout counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
reqN_empty  in  1  requester N FIFO empty (N=0,1; first-word-fall-through)
reqN_tms  in  8  requester N head TMS byte
reqN_tdi  in  8  requester N head TDI byte
reqN_bits  in  3  requester N head bit count
reqN_command  in  5  requester N head command (FIFO_CMD_* codes)
reqN_read  in  8  requester N head read flags
reqN_re  out  1  pop requester N
out_seq_empty  out  1  to jtag_controller
out_seq_tms/tdi/read  out  8 each  muxed head fields
out_seq_bits  out  3  muxed head field
out_seq_command  out  5  muxed head field
out_seq_re  in  1  pop from jtag_controller
in_seq_we  in  1  TDO byte valid from jtag_controller
in_seq_tdo  in  8  TDO byte
in_seq_flushed  in  1  flushed level from jtag_controller
in_seq_full  out  1  muxed owner response-full
rspN_full  in  1  requester N response FIFO full
rspN_we  out  1  TDO byte write to requester N
rspN_tdo  out  8  TDO byte to requester N
rspN_flushed  out  1  one-cycle pulse: N's sequence complete
arb_timeout  out  2  one-hot, one-cycle pulse: requester N forcibly released

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, owner=0, last=1, store_rem=0, counters 0. All outputs 0 except out_seq_empty=1. Mux data outputs drive 0 while in IDLE.
- States: IDLE, OWN, DRAIN. The owner register is held through OWN and DRAIN.
- Data path (combinational):
  - out_seq_* = owner head.
  - out_seq_empty = 1 unless state==OWN and owner not empty.
  - reqN_re = out_seq_re & state==OWN & owner==N.
- IDLE:
  - If exactly one requester is non-empty, grant it.
  - If both are non-empty, grant !last (round-robin). After reset, requester 0 wins first.
  - Grant is registered: the next state is OWN and out_seq_empty stays 1 during the grant cycle.
- OWN:
  - On each pop (out_seq_re with out_seq_empty=0) and store_rem==0:
    - STORE command: store_rem <= {tdi, tms[7:3]} + (tms[2:0]!=0). 13-bit arithmetic, wraps at 8192.
    - FLUSH command: next state DRAIN.
  - On each pop with store_rem!=0: store_rem decrements and the command field is ignored. A payload word whose command field equals FLUSH does not end ownership.
- DRAIN:
  - Lasts at least 2 cycles, then exits to IDLE in the first cycle where the DRAIN count is ≥2 and in_seq_flushed=1.
  - On exit: pulse rsp[owner]_flushed, last <= owner.
  - With a FLUSH popped at cycle t, the trailing partial TDO byte written at t+2 is still routed to the owner.
- Return path:
  - rspN_we = in_seq_we & state!=IDLE & owner==N; rspN_tdo = in_seq_tdo.
  - in_seq_full = rsp[owner]_full when state!=IDLE, else 0.
  - in_seq_we seen in IDLE is dropped.
- Timeout:
  - Counter runs in OWN while the owner is empty and store_rem==0. Cleared on any pop and on entry to OWN.
  - On reaching TIMEOUT: state IDLE, pulse arb_timeout[owner], last <= owner. No flushed pulse.
  - Suspended while store_rem!=0: a requester must complete a STORE payload.
- Simultaneous events:
  - FLUSH pop in the same cycle the timeout would fire: FLUSH wins, go to DRAIN.
  - The non-owner's FIFO becoming non-empty has no effect until IDLE.

Test Plan:
- Both empty after reset, then req0 and req1 each push WR(tms=0x00, tdi=0xA5, bits=0), FLUSH in the same cycle → req0 granted first; out_seq_empty=1 for one cycle; req1's words reach out_seq only after rsp0_flushed pulses; req1 is then granted.
- req0 sends STORE with tdi=0x00, tms=0x1A (words=3+1=4), then 4 payload words whose command field = FLUSH code, then FLUSH → ownership held through the payload; DRAIN entered only on the 6th pop.
- req1 owns and performs a read sequence; jtag_controller returns 3 TDO bytes, the last at t+2 after the FLUSH pop → all 3 on rsp1_we, none on rsp0_we, rsp1_flushed pulses at t+3.
- TIMEOUT=16: req0 sends one WR and stalls empty → arb_timeout=2'b01 pulse 16 cycles after the last pop; req1 then granted.
- rsp0_full=1 while req0 owns → in_seq_full=1; rsp1_full=1 has no effect on in_seq_full.
- rst asserted mid-DRAIN (asynchronous, between clock edges) → out_seq_empty=1 and all reqN_re=0 immediately; no flushed pulse; IDLE after release; next grant goes to req0.
